// File: rtl/obstacle_detector.sv
// obstacle_detector: echo timestamp to distance in cm, with debounced obstacle flag and sensor-fault timeout
module obstacle_detector #(
    parameter int CNT_PER_CM  = 5830,
    parameter int NEAR_CNT    = 116600,
    parameter int FAR_CNT     = 145750,
    parameter int MAX_CNT     = 1156852,
    parameter int HIT_N       = 3,
    parameter int CLEAR_N     = 2,
    parameter int TIMEOUT_CYC = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        control,
    input  logic [22:0] s_echo,
    output logic [10:0] dist_cm,
    output logic        dist_valid,
    output logic        obstacle,
    output logic        sensor_fault
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  DIVIDE   = 2'd1;
    localparam logic [1:0]  CLASSIFY = 2'd2;
    localparam logic [14:0] DIV      = 15'(CNT_PER_CM);
    localparam logic [22:0] NEAR     = 23'(NEAR_CNT);
    localparam logic [22:0] FAR      = 23'(FAR_CNT);
    localparam logic [22:0] MAX      = 23'(MAX_CNT);
    localparam logic [23:0] TO       = 24'(TIMEOUT_CYC);
    localparam logic [3:0]  HIT_TH   = 4'(HIT_N);
    localparam logic [3:0]  CLR_TH   = 4'(CLEAR_N);

    logic [1:0]  state;
    logic        prev_nz;
    logic [22:0] smp;
    logic [22:0] quo;
    logic [13:0] rem;
    logic [4:0]  idx;
    logic [3:0]  hit_cnt;
    logic [3:0]  clr_cnt;
    logic [23:0] to_cnt;

    logic        new_smp;
    logic [14:0] trial;
    logic        ge;
    logic [13:0] rem_nxt;
    logic        near;
    logic        far;
    logic [3:0]  hit_nxt;
    logic [3:0]  clr_nxt;
    logic        obs_nxt;
    logic [10:0] q_sat;
    logic [23:0] to_nxt;

    // Divider step, classification and saturating counter next-values
    always_comb begin
        new_smp = (s_echo != 23'd0) && !prev_nz;
        trial   = {rem, smp[idx]};
        ge      = trial >= DIV;
        rem_nxt = ge ? 14'(trial - DIV) : trial[13:0];
        near    = (smp <= NEAR) && (smp < MAX);
        far     = (smp > FAR) || (smp >= MAX);
        hit_nxt = near ? ((&hit_cnt) ? hit_cnt : hit_cnt + 4'd1) : far ? 4'd0 : hit_cnt;
        clr_nxt = far ? ((&clr_cnt) ? clr_cnt : clr_cnt + 4'd1) : near ? 4'd0 : clr_cnt;
        obs_nxt = (hit_nxt >= HIT_TH) ? 1'b1 : (clr_nxt >= CLR_TH) ? 1'b0 : obstacle;
        q_sat   = (|quo[22:11]) ? 11'h7ff : quo[10:0];
        to_nxt  = (&to_cnt) ? to_cnt : to_cnt + 24'd1;
    end

    // Remember whether s_echo was nonzero so only its rising edge starts a sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_nz <= 1'b0;
        else
            prev_nz <= s_echo != 23'd0;
    end

    // Sequencer: capture in IDLE, one restoring-divide bit per cycle MSB first, then classify
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            smp   <= 23'd0;
            quo   <= 23'd0;
            rem   <= 14'd0;
            idx   <= 5'd0;
        end else if (!control) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (new_smp) begin
                smp   <= s_echo;
                quo   <= 23'd0;
                rem   <= 14'd0;
                idx   <= 5'd22;
                state <= DIVIDE;
            end
        end else if (state == DIVIDE) begin
            rem   <= rem_nxt;
            quo   <= {quo[21:0], ge};
            idx   <= idx - 5'd1;
            state <= (idx == 5'd0) ? CLASSIFY : DIVIDE;
        end else begin
            state <= IDLE;
        end
    end

    // Publish results, debounce the obstacle flag and run the no-sample watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dist_cm      <= 11'd0;
            dist_valid   <= 1'b0;
            obstacle     <= 1'b0;
            sensor_fault <= 1'b0;
            hit_cnt      <= 4'd0;
            clr_cnt      <= 4'd0;
            to_cnt       <= 24'd0;
        end else if (!control) begin
            dist_valid   <= 1'b0;
            obstacle     <= 1'b0;
            sensor_fault <= 1'b0;
            hit_cnt      <= 4'd0;
            clr_cnt      <= 4'd0;
            to_cnt       <= 24'd0;
        end else if (state == CLASSIFY) begin
            dist_cm      <= q_sat;
            dist_valid   <= 1'b1;
            hit_cnt      <= hit_nxt;
            clr_cnt      <= clr_nxt;
            obstacle     <= obs_nxt;
            to_cnt       <= 24'd0;
            sensor_fault <= 1'b0;
        end else begin
            dist_valid   <= 1'b0;
            to_cnt       <= to_nxt;
            if (to_nxt >= TO)
                sensor_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obstacle_detector.sv
// tb_obstacle_detector: directed stimulus with a scoreboard queue checked on every dist_valid pulse
module tb_obstacle_detector;

    localparam int TO = 400;

    typedef struct {
        int         cyc;
        logic [10:0] cm;
        logic        obs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control = 1'b1;
    logic [22:0] s_echo = 23'd0;
    logic [10:0] dist_cm;
    logic        dist_valid;
    logic        obstacle;
    logic        sensor_fault;

    int   cyc = 0;
    int   last_v = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    obstacle_detector #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .reset(reset),
        .control(control),
        .s_echo(s_echo),
        .dist_cm(dist_cm),
        .dist_valid(dist_valid),
        .obstacle(obstacle),
        .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Monitor: every dist_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (dist_valid) begin
            last_v = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1'b0, $sformatf("dist_valid at cyc=%0d dist_cm=%0d, required no pulse", cyc, dist_cm));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", cyc == e.cyc && dist_cm == e.cm && obstacle == e.obs && !sensor_fault,
                    $sformatf("got cyc=%0d dist_cm=%0d obstacle=%0b fault=%0b, required cyc=%0d dist_cm=%0d obstacle=%0b fault=0",
                              cyc, dist_cm, obstacle, sensor_fault, e.cyc, e.cm, e.obs));
            end
        end
    end

    task automatic sample(input logic [22:0] val, input int hold, input logic [10:0] cm, input logic obs);
        @(negedge clk);
        s_echo = val;
        sb.push_back('{cyc + 25, cm, obs});
        repeat (hold) @(negedge clk);
        s_echo = 23'd0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", dist_cm == 0 && !dist_valid && !obstacle && !sensor_fault,
            $sformatf("got dist_cm=%0d valid=%0b obstacle=%0b fault=%0b, required all 0", dist_cm, dist_valid, obstacle, sensor_fault));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        sample(23'd116600, 10, 11'd20, 1'b0);

        @(negedge clk);
        s_echo = 23'd58300;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", dist_cm == 0 && !dist_valid && !obstacle && !sensor_fault,
               $sformatf("got dist_cm=%0d valid=%0b obstacle=%0b fault=%0b, required all 0", dist_cm, dist_valid, obstacle, sensor_fault));
        s_echo = 23'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        sample(23'd58300, 10, 11'd10, 1'b0);
        sample(23'd58300, 10, 11'd10, 1'b0);
        sample(23'd58300, 10, 11'd10, 1'b1);
        sample(23'd200000, 10, 11'd34, 1'b1);
        sample(23'd200000, 10, 11'd34, 1'b0);

        sample(23'd58300, 10, 11'd10, 1'b0);
        sample(23'd58300, 10, 11'd10, 1'b0);
        sample(23'd58300, 60, 11'd10, 1'b1);
        for (int i = 0; i < 5; i++) sample(23'd130000, 10, 11'd22, 1'b1);

        sample(23'd1156852, 10, 11'd198, 1'b1);
        sample(23'd8388607, 10, 11'd1438, 1'b0);

        for (int i = 0; i < 3 * TO && !sensor_fault; i++) @(negedge clk);
        chk("timeout", sensor_fault && (cyc - last_v) == TO,
            $sformatf("got fault=%0b after %0d cycles, required fault=1 after %0d", sensor_fault, cyc - last_v, TO));
        sample(23'd116600, 10, 11'd20, 1'b0);
        chk("fault_cleared", !sensor_fault, $sformatf("got fault=%0b, required 0", sensor_fault));

        sample(23'd58300, 10, 11'd10, 1'b0);
        sample(23'd58300, 10, 11'd10, 1'b1);
        @(negedge clk);
        s_echo = 23'd116600;
        repeat (10) @(negedge clk);
        s_echo = 23'd0;
        control = 1'b0;
        repeat (3) @(negedge clk);
        chk("control_low", !obstacle && !sensor_fault && !dist_valid && dist_cm == 10,
            $sformatf("got obstacle=%0b fault=%0b valid=%0b dist_cm=%0d, required 0 0 0 10", obstacle, sensor_fault, dist_valid, dist_cm));
        repeat (30) @(negedge clk);
        control = 1'b1;
        repeat (2) @(negedge clk);
        sample(23'd116600, 10, 11'd20, 1'b0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        chk("drain", sb.size() == 0, $sformatf("got %0d outstanding results, required 0", sb.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
